axi4_lite_slave_regfile: RTL and testbench

AXI4_LITE_SLAVE_REGFILE -- requirements
Module: axi4_lite_slave_regfile

---
 rtl/axi4_lite_pkg.sv | 34 +++
 rtl/axi4_lite_strb_regs.sv | 33 +++
 rtl/axi4_lite_slave_regfile.sv | 151 +++++++++++++++
 tb/tb_axi4_lite_slave_regfile.sv | 362 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/axi4_lite_pkg.sv
// Shared AXI4-Lite definitions: bus widths, response codes and the slave's FSM encodings.
// The master adaptor imports this same package so both ends agree on codes and widths.
package axi4_lite_pkg;

   localparam int ADDR_WIDTH = 32;
   localparam int DATA_WIDTH = 32;
   localparam int STRB_WIDTH = DATA_WIDTH / 8;

   localparam logic [1:0] RESP_OKAY   = 2'b00;
   localparam logic [1:0] RESP_EXOKAY = 2'b01;
   localparam logic [1:0] RESP_SLVERR = 2'b10;
   localparam logic [1:0] RESP_DECERR = 2'b11;

   typedef enum logic {
      WR_IDLE = 1'b0,
      WR_RESP = 1'b1
   } wr_state_t;

   typedef enum logic {
      RD_IDLE = 1'b0,
      RD_DATA = 1'b1
   } rd_state_t;

   // Expands a byte strobe into a bit mask, one full byte per strobe bit.
   function automatic logic [DATA_WIDTH-1:0] strb_mask(input logic [STRB_WIDTH-1:0] strb);
      logic [DATA_WIDTH-1:0] mask;
      mask = '0;
      for (int i = 0; i < STRB_WIDTH; i++) begin
         mask[8*i +: 8] = {8{strb[i]}};
      end
      return mask;
   endfunction

endpackage

// File: rtl/axi4_lite_strb_regs.sv
// Register array with one byte-strobed write port and one combinational read port.
// A same-edge read therefore sees the value from before the write lands.
import axi4_lite_pkg::*;

module axi4_lite_strb_regs #(
   parameter int NUM_REGS = 16,
   parameter int IDX_W    = $clog2(NUM_REGS)
) (
   input  logic                  clk,
   input  logic                  resetn,
   input  logic                  we,
   input  logic [IDX_W-1:0]      waddr,
   input  logic [DATA_WIDTH-1:0] wdata,
   input  logic [STRB_WIDTH-1:0] wstrb,
   input  logic [IDX_W-1:0]      raddr,
   output logic [DATA_WIDTH-1:0] rdata
);

   logic [DATA_WIDTH-1:0] regs [NUM_REGS];

   always_ff @(posedge clk) begin
      if (!resetn) begin
         for (int i = 0; i < NUM_REGS; i++) begin
            regs[i] <= '0;
         end
      end else if (we) begin
         regs[waddr] <= (regs[waddr] & ~strb_mask(wstrb)) | (wdata & strb_mask(wstrb));
      end
   end

   assign rdata = regs[raddr];

endmodule

// File: rtl/axi4_lite_slave_regfile.sv
// AXI4-Lite slave exposing NUM_REGS 32-bit registers indexed by addr[7:2].
// AW and W are captured independently; the write commits one edge after both are held.
import axi4_lite_pkg::*;

module axi4_lite_slave_regfile #(
   parameter int NUM_REGS = 16
) (
   input  logic                  aclk,
   input  logic                  aresetn,
   input  logic [ADDR_WIDTH-1:0] awaddr_in,
   input  logic [2:0]            awprot_in,
   input  logic                  awvalid_in,
   output logic                  awready_out,
   input  logic [DATA_WIDTH-1:0] wdata_in,
   input  logic [STRB_WIDTH-1:0] wstrb_in,
   input  logic                  wvalid_in,
   output logic                  wready_out,
   output logic [1:0]            bresp_out,
   output logic                  bvalid_out,
   input  logic                  bready_in,
   input  logic [ADDR_WIDTH-1:0] araddr_in,
   input  logic [2:0]            arprot_in,
   input  logic                  arvalid_in,
   output logic                  arready_out,
   output logic [DATA_WIDTH-1:0] rdata_out,
   output logic [1:0]            rresp_out,
   output logic                  rvalid_out,
   input  logic                  rready_in
);

   localparam int IDX_W = $clog2(NUM_REGS);

   wr_state_t             wr_state;
   rd_state_t             rd_state;
   logic                  aw_held;
   logic                  w_held;
   logic [5:0]            aw_idx;
   logic [DATA_WIDTH-1:0] w_data;
   logic [STRB_WIDTH-1:0] w_strb;
   logic                  aw_fire;
   logic                  w_fire;
   logic                  commit;
   logic                  aw_in_range;
   logic [5:0]            ar_idx;
   logic                  ar_in_range;
   logic                  ar_fire;
   logic                  reg_we;
   logic [DATA_WIDTH-1:0] reg_rdata;
   logic                  unused_bits;

   // Protection bits and address bits outside [7:2] carry no meaning for this block.
   assign unused_bits = ^{awprot_in, arprot_in, awaddr_in[31:8], awaddr_in[1:0],
                          araddr_in[31:8], araddr_in[1:0]};

   assign awready_out = aresetn & ~aw_held & ~bvalid_out;
   assign wready_out  = aresetn & ~w_held & ~bvalid_out;
   assign arready_out = aresetn & (rd_state == RD_IDLE);

   assign aw_fire     = awvalid_in & awready_out;
   assign w_fire      = wvalid_in & wready_out;
   assign commit      = (wr_state == WR_IDLE) & aw_held & w_held;
   assign aw_in_range = ({26'd0, aw_idx} < 32'(NUM_REGS));
   assign reg_we      = commit & aw_in_range;

   assign ar_idx      = araddr_in[7:2];
   assign ar_in_range = ({26'd0, ar_idx} < 32'(NUM_REGS));
   assign ar_fire     = arvalid_in & arready_out;

   axi4_lite_strb_regs #(
      .NUM_REGS (NUM_REGS)
   ) u_regs (
      .clk    (aclk),
      .resetn (aresetn),
      .we     (reg_we),
      .waddr  (aw_idx[IDX_W-1:0]),
      .wdata  (w_data),
      .wstrb  (w_strb),
      .raddr  (ar_idx[IDX_W-1:0]),
      .rdata  (reg_rdata)
   );

   // Write side: hold AW and W until both are present, then commit and respond.
   always_ff @(posedge aclk) begin
      if (!aresetn) begin
         wr_state   <= WR_IDLE;
         aw_held    <= 1'b0;
         w_held     <= 1'b0;
         aw_idx     <= '0;
         w_data     <= '0;
         w_strb     <= '0;
         bvalid_out <= 1'b0;
         bresp_out  <= RESP_OKAY;
      end else begin
         case (wr_state)
            WR_IDLE: begin
               if (commit) begin
                  wr_state   <= WR_RESP;
                  bvalid_out <= 1'b1;
                  bresp_out  <= aw_in_range ? RESP_OKAY : RESP_SLVERR;
                  aw_held    <= 1'b0;
                  w_held     <= 1'b0;
               end else begin
                  if (aw_fire) begin
                     aw_held <= 1'b1;
                     aw_idx  <= awaddr_in[7:2];
                  end
                  if (w_fire) begin
                     w_held <= 1'b1;
                     w_data <= wdata_in;
                     w_strb <= wstrb_in;
                  end
               end
            end
            WR_RESP: begin
               if (bready_in) begin
                  wr_state   <= WR_IDLE;
                  bvalid_out <= 1'b0;
               end
            end
         endcase
      end
   end

   // Read side: sample the array on the AR handshake and hold the beat until accepted.
   always_ff @(posedge aclk) begin
      if (!aresetn) begin
         rd_state   <= RD_IDLE;
         rvalid_out <= 1'b0;
         rresp_out  <= RESP_OKAY;
         rdata_out  <= '0;
      end else begin
         case (rd_state)
            RD_IDLE: begin
               if (ar_fire) begin
                  rd_state   <= RD_DATA;
                  rvalid_out <= 1'b1;
                  rresp_out  <= ar_in_range ? RESP_OKAY : RESP_SLVERR;
                  rdata_out  <= ar_in_range ? reg_rdata : '0;
               end
            end
            RD_DATA: begin
               if (rready_in) begin
                  rd_state   <= RD_IDLE;
                  rvalid_out <= 1'b0;
               end
            end
         endcase
      end
   end

endmodule

// File: tb/tb_axi4_lite_slave_regfile.sv
// Self-checking bench for axi4_lite_slave_regfile: constant vector table, corner-case
// sequences, then randomized traffic compared against a word-array reference model.
module tb_axi4_lite_slave_regfile;

   localparam int NREGS = 16;

   logic        aclk;
   logic        aresetn;
   logic [31:0] awaddr_in;
   logic [2:0]  awprot_in;
   logic        awvalid_in;
   logic        awready_out;
   logic [31:0] wdata_in;
   logic [3:0]  wstrb_in;
   logic        wvalid_in;
   logic        wready_out;
   logic [1:0]  bresp_out;
   logic        bvalid_out;
   logic        bready_in;
   logic [31:0] araddr_in;
   logic [2:0]  arprot_in;
   logic        arvalid_in;
   logic        arready_out;
   logic [31:0] rdata_out;
   logic [1:0]  rresp_out;
   logic        rvalid_out;
   logic        rready_in;

   int errors = 0;
   int checks = 0;

   logic [31:0] model_regs [NREGS];

   typedef struct {
      bit          is_write;
      logic [31:0] addr;
      logic [31:0] data;
      logic [3:0]  strb;
      logic [31:0] exp_data;
      logic [1:0]  exp_resp;
   } vector_t;

   vector_t vecs [14];

   axi4_lite_slave_regfile #(
      .NUM_REGS (NREGS)
   ) dut (
      .aclk        (aclk),
      .aresetn     (aresetn),
      .awaddr_in   (awaddr_in),
      .awprot_in   (awprot_in),
      .awvalid_in  (awvalid_in),
      .awready_out (awready_out),
      .wdata_in    (wdata_in),
      .wstrb_in    (wstrb_in),
      .wvalid_in   (wvalid_in),
      .wready_out  (wready_out),
      .bresp_out   (bresp_out),
      .bvalid_out  (bvalid_out),
      .bready_in   (bready_in),
      .araddr_in   (araddr_in),
      .arprot_in   (arprot_in),
      .arvalid_in  (arvalid_in),
      .arready_out (arready_out),
      .rdata_out   (rdata_out),
      .rresp_out   (rresp_out),
      .rvalid_out  (rvalid_out),
      .rready_in   (rready_in)
   );

   initial aclk = 1'b0;
   always #5 aclk = ~aclk;

   initial begin
      #2_000_000;
      $display("[TB] FAIL watchdog: simulation time limit reached");
      $fatal(1, "[TB] watchdog expired");
   end

   task automatic step();
      @(posedge aclk);
      #1;
   endtask

   task automatic check_output(input string name, input logic [31:0] actual, input logic [31:0] expected);
      checks++;
      if (actual !== expected) begin
         errors++;
         $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, actual, expected);
      end
   endtask

   // Reference model: registers are plain words, a write merges data through a byte mask.
   function automatic bit model_in_range(input logic [31:0] addr);
      return int'(addr[7:2]) < NREGS;
   endfunction

   function automatic logic [1:0] model_resp(input logic [31:0] addr);
      return model_in_range(addr) ? 2'b00 : 2'b10;
   endfunction

   task automatic model_write(input logic [31:0] addr, input logic [31:0] data, input logic [3:0] strb);
      logic [31:0] mask;
      mask = {{8{strb[3]}}, {8{strb[2]}}, {8{strb[1]}}, {8{strb[0]}}};
      if (model_in_range(addr))
         model_regs[addr[7:2]] = (model_regs[addr[7:2]] & ~mask) | (data & mask);
   endtask

   function automatic logic [31:0] model_read(input logic [31:0] addr);
      return model_in_range(addr) ? model_regs[addr[7:2]] : 32'h0;
   endfunction

   task automatic apply_write(input logic [31:0] addr, input logic [31:0] data, input logic [3:0] strb,
                              input int b_delay, output logic [1:0] resp);
      bit aw_done = 0;
      bit w_done = 0;
      bit aw_go;
      bit w_go;
      int guard = 0;
      int lat = 0;
      awaddr_in  = addr;
      awprot_in  = 3'($urandom);
      wdata_in   = data;
      wstrb_in   = strb;
      awvalid_in = 1'b1;
      wvalid_in  = 1'b1;
      bready_in  = (b_delay == 0);
      while (!(aw_done && w_done) && guard < 20) begin
         aw_go = awvalid_in && awready_out;
         w_go  = wvalid_in && wready_out;
         step();
         guard++;
         if (aw_go) begin awvalid_in = 1'b0; aw_done = 1; end
         if (w_go)  begin wvalid_in = 1'b0;  w_done = 1;  end
      end
      awvalid_in = 1'b0;
      wvalid_in  = 1'b0;
      check_output("write handshake", 32'(aw_done && w_done), 32'd1);
      while (!bvalid_out && lat < 20) begin
         step();
         lat++;
      end
      check_output("write latency", 32'(lat), 32'd1);
      resp = bresp_out;
      for (int i = 0; i < b_delay; i++) begin
         check_output("bvalid held", 32'(bvalid_out), 32'd1);
         check_output("bresp stable", 32'(bresp_out), 32'(resp));
         check_output("awready low in resp", 32'(awready_out), 32'd0);
         check_output("wready low in resp", 32'(wready_out), 32'd0);
         step();
      end
      bready_in = 1'b1;
      step();
      check_output("bvalid cleared", 32'(bvalid_out), 32'd0);
      bready_in = 1'b0;
   endtask

   task automatic apply_read(input logic [31:0] addr, input int r_delay,
                             output logic [31:0] data, output logic [1:0] resp);
      bit done = 0;
      bit go;
      int guard = 0;
      araddr_in  = addr;
      arprot_in  = 3'($urandom);
      arvalid_in = 1'b1;
      rready_in  = (r_delay == 0);
      while (!done && guard < 20) begin
         go = arready_out;
         step();
         guard++;
         if (go) done = 1;
      end
      arvalid_in = 1'b0;
      check_output("read handshake", 32'(done), 32'd1);
      check_output("rvalid after ar", 32'(rvalid_out), 32'd1);
      data = rdata_out;
      resp = rresp_out;
      for (int i = 0; i < r_delay; i++) begin
         check_output("rvalid held", 32'(rvalid_out), 32'd1);
         check_output("rdata stable", rdata_out, data);
         check_output("rresp stable", 32'(rresp_out), 32'(resp));
         check_output("arready low in data", 32'(arready_out), 32'd0);
         step();
      end
      rready_in = 1'b1;
      step();
      check_output("rvalid cleared", 32'(rvalid_out), 32'd0);
      rready_in = 1'b0;
   endtask

   task automatic apply_stimulus();
      logic [1:0]  resp;
      logic [31:0] data;
      logic [31:0] r;
      logic [5:0]  idx;
      logic [31:0] addr;
      logic [31:0] wd;
      logic [3:0]  ws;

      // Reset state
      aresetn = 1'b0;
      awaddr_in = '0; awprot_in = '0; awvalid_in = 1'b0;
      wdata_in = '0; wstrb_in = '0; wvalid_in = 1'b0; bready_in = 1'b0;
      araddr_in = '0; arprot_in = '0; arvalid_in = 1'b0; rready_in = 1'b0;
      for (int i = 0; i < NREGS; i++) model_regs[i] = 32'h0;
      repeat (3) step();
      check_output("reset awready", 32'(awready_out), 32'd0);
      check_output("reset wready", 32'(wready_out), 32'd0);
      check_output("reset arready", 32'(arready_out), 32'd0);
      check_output("reset bvalid", 32'(bvalid_out), 32'd0);
      check_output("reset rvalid", 32'(rvalid_out), 32'd0);
      check_output("reset bresp", 32'(bresp_out), 32'd0);
      check_output("reset rresp", 32'(rresp_out), 32'd0);
      check_output("reset rdata", rdata_out, 32'd0);
      aresetn = 1'b1;
      #1;
      check_output("idle awready", 32'(awready_out), 32'd1);
      check_output("idle wready", 32'(wready_out), 32'd1);
      check_output("idle arready", 32'(arready_out), 32'd1);

      // Constant vector table
      vecs[0]  = '{1, 32'h10,  32'hF0B4A596, 4'b1011, 32'h0,        2'b00};
      vecs[1]  = '{0, 32'h10,  32'h0,        4'h0,    32'hF000A596, 2'b00};
      vecs[2]  = '{1, 32'h40,  32'hDEADBEEF, 4'b1111, 32'h0,        2'b10};
      vecs[3]  = '{0, 32'h40,  32'h0,        4'h0,    32'h0,        2'b10};
      vecs[4]  = '{1, 32'h00,  32'h11223344, 4'b0001, 32'h0,        2'b00};
      vecs[5]  = '{0, 32'h00,  32'h0,        4'h0,    32'h00000044, 2'b00};
      vecs[6]  = '{1, 32'h3E,  32'hCAFEBABE, 4'b1100, 32'h0,        2'b00};
      vecs[7]  = '{0, 32'h3C,  32'h0,        4'h0,    32'hCAFE0000, 2'b00};
      vecs[8]  = '{0, 32'hFC,  32'h0,        4'h0,    32'h0,        2'b10};
      vecs[9]  = '{1, 32'h11,  32'h01020304, 4'b0110, 32'h0,        2'b00};
      vecs[10] = '{0, 32'h10,  32'h0,        4'h0,    32'hF0020396, 2'b00};
      vecs[11] = '{1, 32'h104, 32'hA5A5A5A5, 4'b1111, 32'h0,        2'b00};
      vecs[12] = '{0, 32'h04,  32'h0,        4'h0,    32'hA5A5A5A5, 2'b00};
      vecs[13] = '{0, 32'h08,  32'h0,        4'h0,    32'h0,        2'b00};
      for (int k = 0; k < 14; k++) begin
         if (vecs[k].is_write) begin
            apply_write(vecs[k].addr, vecs[k].data, vecs[k].strb, 0, resp);
            check_output($sformatf("vec%0d bresp", k), 32'(resp), 32'(vecs[k].exp_resp));
            model_write(vecs[k].addr, vecs[k].data, vecs[k].strb);
         end else begin
            apply_read(vecs[k].addr, 0, data, resp);
            check_output($sformatf("vec%0d rdata", k), data, vecs[k].exp_data);
            check_output($sformatf("vec%0d rresp", k), 32'(resp), 32'(vecs[k].exp_resp));
         end
      end

      // W arrives three cycles before AW
      bready_in = 1'b1;
      wdata_in  = 32'h12345678;
      wstrb_in  = 4'hF;
      wvalid_in = 1'b1;
      check_output("w-first wready", 32'(wready_out), 32'd1);
      step();
      wvalid_in = 1'b0;
      for (int i = 0; i < 3; i++) begin
         check_output("w-first wready held low", 32'(wready_out), 32'd0);
         check_output("w-first no bvalid", 32'(bvalid_out), 32'd0);
         step();
      end
      awaddr_in  = 32'h3C;
      awvalid_in = 1'b1;
      check_output("w-first awready", 32'(awready_out), 32'd1);
      step();
      awvalid_in = 1'b0;
      check_output("w-first bvalid not yet", 32'(bvalid_out), 32'd0);
      step();
      check_output("w-first bvalid", 32'(bvalid_out), 32'd1);
      check_output("w-first bresp", 32'(bresp_out), 32'd0);
      step();
      check_output("w-first single response", 32'(bvalid_out), 32'd0);
      check_output("w-first awready back", 32'(awready_out), 32'd1);
      check_output("w-first wready back", 32'(wready_out), 32'd1);
      bready_in = 1'b0;
      model_write(32'h3C, 32'h12345678, 4'hF);
      apply_read(32'h3C, 0, data, resp);
      check_output("w-first readback", data, 32'h12345678);

      // Backpressure on both response channels
      apply_write(32'h08, 32'h55AA55AA, 4'hF, 5, resp);
      check_output("bp bresp", 32'(resp), 32'd0);
      model_write(32'h08, 32'h55AA55AA, 4'hF);
      apply_read(32'h08, 5, data, resp);
      check_output("bp rdata", data, 32'h55AA55AA);
      check_output("bp rresp", 32'(resp), 32'd0);

      // Read sampled on the same edge as a write commit to index 4
      awaddr_in = 32'h10; wdata_in = 32'hAAAAAAAA; wstrb_in = 4'hF;
      awvalid_in = 1'b1; wvalid_in = 1'b1;
      step();
      awvalid_in = 1'b0; wvalid_in = 1'b0;
      araddr_in = 32'h10; arvalid_in = 1'b1;
      check_output("collide arready", 32'(arready_out), 32'd1);
      step();
      arvalid_in = 1'b0;
      check_output("collide bvalid", 32'(bvalid_out), 32'd1);
      check_output("collide rvalid", 32'(rvalid_out), 32'd1);
      check_output("collide old value", rdata_out, 32'hF0020396);
      bready_in = 1'b1; rready_in = 1'b1;
      step();
      check_output("collide bvalid done", 32'(bvalid_out), 32'd0);
      check_output("collide rvalid done", 32'(rvalid_out), 32'd0);
      bready_in = 1'b0; rready_in = 1'b0;
      model_write(32'h10, 32'hAAAAAAAA, 4'hF);
      apply_read(32'h10, 0, data, resp);
      check_output("collide new value", data, 32'hAAAAAAAA);

      // Randomized traffic against the reference model
      for (int n = 0; n < 60; n++) begin
         r    = $urandom();
         idx  = 6'($urandom_range(0, 19));
         addr = {r[31:8], idx, r[1:0]};
         if ($urandom_range(0, 1) == 1) begin
            wd = $urandom();
            ws = 4'($urandom_range(0, 15));
            apply_write(addr, wd, ws, $urandom_range(0, 3), resp);
            check_output($sformatf("rand%0d bresp", n), 32'(resp), 32'(model_resp(addr)));
            model_write(addr, wd, ws);
         end else begin
            apply_read(addr, $urandom_range(0, 3), data, resp);
            check_output($sformatf("rand%0d rdata", n), data, model_read(addr));
            check_output($sformatf("rand%0d rresp", n), 32'(resp), 32'(model_resp(addr)));
         end
      end

      // Reset between AW capture and W
      awaddr_in = 32'h20; awvalid_in = 1'b1;
      step();
      awvalid_in = 1'b0;
      check_output("mid-reset aw held", 32'(awready_out), 32'd0);
      aresetn = 1'b0;
      #1;
      check_output("in-reset awready", 32'(awready_out), 32'd0);
      check_output("in-reset wready", 32'(wready_out), 32'd0);
      check_output("in-reset arready", 32'(arready_out), 32'd0);
      step();
      aresetn = 1'b1;
      #1;
      check_output("post-reset awready", 32'(awready_out), 32'd1);
      for (int i = 0; i < NREGS; i++) model_regs[i] = 32'h0;
      wdata_in = 32'hFFFFFFFF; wstrb_in = 4'hF; wvalid_in = 1'b1; bready_in = 1'b1;
      step();
      wvalid_in = 1'b0;
      for (int i = 0; i < 4; i++) begin
         check_output("post-reset no response", 32'(bvalid_out), 32'd0);
         step();
      end
      bready_in = 1'b0;
      for (int i = 0; i <= NREGS; i++) begin
         apply_read(32'(i * 4), 0, data, resp);
         check_output($sformatf("post-reset read%0d", i), data, model_read(32'(i * 4)));
         check_output($sformatf("post-reset rresp%0d", i), 32'(resp), 32'(model_resp(32'(i * 4))));
      end
   endtask

   initial begin
      apply_stimulus();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
